// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes,
// memory-wait freeze with watchdog, halt handling and stall statistics.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  D_Rs,
    input  logic [2:0]  D_Rt,
    input  logic        D_UsesRs,
    input  logic        D_UsesRt,
    input  logic        E_MemRead,
    input  logic        E_RegWrite,
    input  logic [2:0]  E_WriteReg,
    input  logic        BranchJumpTaken,
    input  logic        Halt,
    input  logic        MemStall,
    input  logic        MemDone,
    output logic        PCWrite,
    output logic        Stall_FD,
    output logic        Bubble_DE,
    output logic        Flush_FD,
    output logic        Flush_DE,
    output logic        Freeze,
    output logic        Halted,
    output logic [15:0] StallCount,
    output logic        Err
);

    typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        err_q, err_d;

    logic load_use;
    logic eval_run;
    logic pc_write, stall_fd, bubble_de, flush_fd, flush_de, freeze, halted;

    assign load_use = E_MemRead & E_RegWrite &
                      ((D_UsesRs & (D_Rs == E_WriteReg)) |
                       (D_UsesRt & (D_Rt == E_WriteReg)));

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        eval_run    = 1'b0;
        pc_write    = 1'b0;
        stall_fd    = 1'b0;
        bubble_de   = 1'b0;
        flush_fd    = 1'b0;
        flush_de    = 1'b0;
        freeze      = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            RUN: begin
                if (MemDone)
                    err_d = 1'b1;
                eval_run = 1'b1;
            end
            MEMWAIT: begin
                if (MemStall)
                    err_d = 1'b1;
                if (MemDone) begin
                    state_d  = RUN;
                    eval_run = 1'b1;
                end else if (wait_q == 8'd254) begin
                    freeze  = 1'b1;
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    freeze = 1'b1;
                    wait_d = wait_q + 8'd1;
                end
            end
            HALT: begin
                freeze = 1'b1;
                halted = 1'b1;
            end
            default: state_d = RUN;
        endcase

        // MemStall only opens a wait from RUN; in MEMWAIT it is a fault
        if (eval_run) begin
            if (Halt) begin
                freeze  = 1'b1;
                state_d = HALT;
            end else if (MemStall && state_q == RUN) begin
                freeze  = 1'b1;
                wait_d  = 8'd0;
                state_d = MEMWAIT;
            end else if (BranchJumpTaken) begin
                pc_write = 1'b1;
                flush_fd = 1'b1;
                flush_de = 1'b1;
            end else if (load_use) begin
                stall_fd  = 1'b1;
                bubble_de = 1'b1;
            end else begin
                pc_write = 1'b1;
            end
        end

        if ((freeze || stall_fd) && state_q != HALT && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= 8'd0;
            stall_cnt_q <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    // Reset forces a flushed, non-advancing pipeline regardless of state
    assign PCWrite    = rst ? 1'b0  : pc_write;
    assign Stall_FD   = rst ? 1'b0  : stall_fd;
    assign Bubble_DE  = rst ? 1'b0  : bubble_de;
    assign Flush_FD   = rst ? 1'b1  : flush_fd;
    assign Flush_DE   = rst ? 1'b1  : flush_de;
    assign Freeze     = rst ? 1'b0  : freeze;
    assign Halted     = rst ? 1'b0  : halted;
    assign StallCount = rst ? 16'd0 : stall_cnt_q;
    assign Err        = rst ? 1'b0  : err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues expected outputs,
// monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  rs, rt, wr;
    logic        urs, urt, mr, rw, bj, hl, ms, md;
    logic        PCWrite, Stall_FD, Bubble_DE, Flush_FD, Flush_DE;
    logic        Freeze, Halted, Err;
    logic [15:0] StallCount;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .D_Rs(rs), .D_Rt(rt), .D_UsesRs(urs), .D_UsesRt(urt),
        .E_MemRead(mr), .E_RegWrite(rw), .E_WriteReg(wr),
        .BranchJumpTaken(bj), .Halt(hl), .MemStall(ms), .MemDone(md),
        .PCWrite(PCWrite), .Stall_FD(Stall_FD), .Bubble_DE(Bubble_DE),
        .Flush_FD(Flush_FD), .Flush_DE(Flush_DE), .Freeze(Freeze),
        .Halted(Halted), .StallCount(StallCount), .Err(Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {PCWrite,Stall_FD,Bubble_DE,Flush_FD,Flush_DE,Freeze,Halted}
    localparam logic [6:0] C_IDLE = 7'b1000000;
    localparam logic [6:0] C_LU   = 7'b0110000;
    localparam logic [6:0] C_BR   = 7'b1001100;
    localparam logic [6:0] C_FRZ  = 7'b0000010;
    localparam logic [6:0] C_HLT  = 7'b0000011;
    localparam logic [6:0] C_RST  = 7'b0001100;

    typedef struct {
        string       name;
        logic [6:0]  ctrl;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = 16'd0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [6:0] act;
            e   = sb.pop_front();
            act = {PCWrite, Stall_FD, Bubble_DE, Flush_FD, Flush_DE, Freeze, Halted};
            checks++;
            if (act !== e.ctrl || StallCount !== e.cnt || Err !== e.err) begin
                errors++;
                $display("FAIL %s: got ctrl=%b cnt=%h err=%b, want ctrl=%b cnt=%h err=%b",
                         e.name, act, StallCount, Err, e.ctrl, e.cnt, e.err);
            end
        end
    end

    task automatic clr();
        rs = 3'd0; rt = 3'd0; wr = 3'd0;
        urs = 1'b0; urt = 1'b0; mr = 1'b0; rw = 1'b0;
        bj = 1'b0; hl = 1'b0; ms = 1'b0; md = 1'b0;
    endtask

    task automatic lu_rs(input logic [2:0] r);
        mr = 1'b1; rw = 1'b1; wr = r; rs = r; urs = 1'b1;
    endtask

    task automatic step(input string nm, input logic [6:0] c,
                        input logic e, input bit chk = 1'b1);
        exp_t x;
        if (chk) begin
            x.name = nm;
            x.ctrl = c;
            x.cnt  = rst ? 16'd0 : exp_cnt;
            x.err  = e;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        if (rst)
            exp_cnt = 16'd0;
        else if ((c[1] || c[5]) && !c[0] && exp_cnt != 16'hFFFF)
            exp_cnt = exp_cnt + 16'd1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("rst0", C_RST, 1'b0);
        step("rst1", C_RST, 1'b0);
        rst = 1'b0;
        step("idle", C_IDLE, 1'b0);

        lu_rs(3'd3);
        step("lu_rs", C_LU, 1'b0);
        clr();
        step("after_lu", C_IDLE, 1'b0);
        mr = 1'b1; rw = 1'b1; wr = 3'd5; rt = 3'd5; urt = 1'b1;
        step("lu_rt", C_LU, 1'b0);
        urt = 1'b0;
        step("no_use", C_IDLE, 1'b0);
        urt = 1'b1; mr = 1'b0;
        step("no_load", C_IDLE, 1'b0);
        mr = 1'b1; rw = 1'b0;
        step("no_wr", C_IDLE, 1'b0);
        rw = 1'b1; wr = 3'd4;
        step("diff_reg", C_IDLE, 1'b0);
        wr = 3'd5; bj = 1'b1;
        step("br_vs_lu", C_BR, 1'b0);
        clr(); bj = 1'b1;
        step("br", C_BR, 1'b0);

        clr(); rst = 1'b1;
        step("rst2", C_RST, 1'b0);
        rst = 1'b0;
        ms = 1'b1; bj = 1'b1;
        step("ms", C_FRZ, 1'b0);
        clr(); hl = 1'b1; bj = 1'b1; lu_rs(3'd3);
        step("mw_ignore", C_FRZ, 1'b0);
        clr();
        for (int i = 2; i <= 5; i++)
            step("mw", C_FRZ, 1'b0);
        md = 1'b1;
        step("md", C_IDLE, 1'b0);
        clr();
        step("mw_cnt6", C_IDLE, 1'b0);

        ms = 1'b1;
        step("ms2", C_FRZ, 1'b0);
        clr();
        step("mw2", C_FRZ, 1'b0);
        md = 1'b1; lu_rs(3'd2);
        step("md_lu", C_LU, 1'b0);
        clr(); ms = 1'b1;
        step("ms3", C_FRZ, 1'b0);
        clr(); md = 1'b1; bj = 1'b1; lu_rs(3'd2);
        step("md_br", C_BR, 1'b0);

        clr(); md = 1'b1;
        step("md_run", C_IDLE, 1'b0);
        clr();
        step("err_md", C_IDLE, 1'b1);
        rst = 1'b1;
        step("rst3", C_RST, 1'b0);
        rst = 1'b0; ms = 1'b1;
        step("ms4", C_FRZ, 1'b0);
        step("ms_mw", C_FRZ, 1'b0);
        clr(); md = 1'b1;
        step("md_err", C_IDLE, 1'b1);
        clr();
        step("err_hold", C_IDLE, 1'b1);

        rst = 1'b1;
        step("rst4", C_RST, 1'b0);
        rst = 1'b0; ms = 1'b1;
        step("ms5", C_FRZ, 1'b0);
        clr();
        step("mw5", C_FRZ, 1'b0);
        rst = 1'b1;
        step("rst_mw", C_RST, 1'b0);
        rst = 1'b0;
        step("run_after_rst", C_IDLE, 1'b0);

        ms = 1'b1;
        step("ms6", C_FRZ, 1'b0);
        clr(); md = 1'b1; hl = 1'b1;
        step("md_halt", C_FRZ, 1'b0);
        clr();
        step("halted", C_HLT, 1'b0);
        ms = 1'b1; bj = 1'b1; lu_rs(3'd1);
        step("halt_hold", C_HLT, 1'b0);
        clr();
        step("halt_hold2", C_HLT, 1'b0);
        rst = 1'b1;
        step("rst_halt", C_RST, 1'b0);
        rst = 1'b0;
        step("idle_after_halt", C_IDLE, 1'b0);

        hl = 1'b1;
        step("halt_run", C_FRZ, 1'b0);
        clr();
        for (int i = 0; i < 4; i++)
            step("halted2", C_HLT, 1'b0);
        rst = 1'b1;
        step("rst5", C_RST, 1'b0);
        rst = 1'b0;
        step("cnt_cleared", C_IDLE, 1'b0);

        ms = 1'b1;
        step("wd_ms", C_FRZ, 1'b0);
        clr();
        for (int i = 1; i <= 255; i++)
            step("wd_wait", C_FRZ, 1'b0, (i <= 2) || (i >= 253));
        step("wd_halt", C_HLT, 1'b1);
        md = 1'b1;
        for (int i = 0; i < 3; i++)
            step("wd_hold", C_HLT, 1'b1);
        clr(); rst = 1'b1;
        step("rst6", C_RST, 1'b0);
        rst = 1'b0;
        step("wd_cleared", C_IDLE, 1'b0);

        mr = 1'b1; rw = 1'b1; wr = 3'd6; rt = 3'd6; urt = 1'b1;
        for (int i = 0; i < 70000; i++)
            step("sat", C_LU, 1'b0,
                 (i >= 65533 && i <= 65537) || i == 69999);
        clr();
        step("sat_hold", C_IDLE, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: D_Rs  in  3  Rs field of instruction in decode.
REQ-004 SHALL have port: D_Rt  in  3  Rt field of instruction in decode.
REQ-005 SHALL have port: D_UsesRs  in  1  decode instruction reads Rs.
REQ-006 SHALL have port: D_UsesRt  in  1  decode instruction reads Rt.
REQ-007 SHALL have port: E_MemRead  in  1  execute-stage instruction is a load.
REQ-008 SHALL have port: E_RegWrite  in  1  execute-stage instruction writes the register file.
REQ-009 SHALL have port: E_WriteReg  in  3  destination register of the execute-stage instruction.
REQ-010 SHALL have port: BranchJumpTaken  in  1  execute resolved a taken branch or jump this cycle.
REQ-011 SHALL have port: Halt  in  1  HALT instruction has reached memory stage.
REQ-012 SHALL have port: MemStall  in  1  memory not ready; single-cycle request pulse.
REQ-013 SHALL have port: MemDone  in  1  memory access complete; single-cycle pulse.
REQ-014 SHALL have port: PCWrite  out  1  PC register may update.
REQ-015 SHALL have port: Stall_FD  out  1  hold F/D pipeline register.
REQ-016 SHALL have port: Bubble_DE  out  1  load a NOP into D/E.
REQ-017 SHALL have port: Flush_FD  out  1  clear F/D to NOP.
REQ-018 SHALL have port: Flush_DE  out  1  clear D/E to NOP.
REQ-019 SHALL have port: Freeze  out  1  hold every pipeline register and PC.
REQ-020 SHALL have port: Halted  out  1  processor stopped.
REQ-021 SHALL have port: StallCount  out  16  stall cycles since reset.
REQ-022 SHALL have port: Err  out  1  sticky fault flag; ORed into processor err.

Function
REQ-023 SHALL implement FSM states: RUN, MEMWAIT, HALT; state register updates on clk.
REQ-024 SHALL assert all outputs combinationally from state and inputs; StallCount, Err and state are registered.
REQ-025 SHALL define LoadUse = E_MemRead & E_RegWrite & ((D_UsesRs & D_Rs==E_WriteReg) | (D_UsesRt & D_Rt==E_WriteReg)).
REQ-026 In RUN, inputs SHALL be resolved with priority Halt > MemStall > BranchJumpTaken > LoadUse.
REQ-027 In RUN with Halt=1: next state HALT; Freeze=1, PCWrite=0 that cycle.
REQ-028 In RUN with MemStall=1 (Halt=0): next state MEMWAIT; Freeze=1, PCWrite=0, no flush or bubble.
REQ-029 In RUN with BranchJumpTaken=1: Flush_FD=1, Flush_DE=1, PCWrite=1; LoadUse ignored.
REQ-030 In RUN with LoadUse=1 only: PCWrite=0, Stall_FD=1, Bubble_DE=1 for exactly that cycle.
REQ-031 In RUN, idle: PCWrite=1; all other control outputs 0.
REQ-032 In MEMWAIT, MemDone=0: Freeze=1, PCWrite=0; Halt, branch and LoadUse ignored.
REQ-033 In MEMWAIT, MemDone=1: next state RUN; Freeze=0; Halt, branch and LoadUse evaluated per RUN rules in that same cycle.
REQ-034 MEMWAIT SHALL use an 8-bit wait counter, cleared on entry; if 255 cycles pass without MemDone, Err SHALL set and state SHALL go to HALT.
REQ-035 In HALT: Freeze=1, PCWrite=0, Halted=1; state held until rst.
REQ-036 StallCount SHALL increment by 1 on every cycle with Freeze=1 or Stall_FD=1 outside HALT, saturating at 0xFFFF.
REQ-037 MemDone in RUN, or MemStall in MEMWAIT, SHALL set Err; state transitions are otherwise unaffected.

Reset
REQ-038 With rst=1 at clk edge: state=RUN, wait counter=0, StallCount=0, Err=0.
REQ-039 While rst=1, outputs SHALL be PCWrite=0, Flush_FD=1, Flush_DE=1, all other outputs 0.
REQ-040 Reset mid-MEMWAIT or in HALT SHALL return to RUN on the next edge, with no residual freeze.

Verification
REQ-041 SHALL check load-use: E_MemRead=1, E_RegWrite=1, E_WriteReg=3, D_Rs=3, D_UsesRs=1 -> one cycle of PCWrite=0, Stall_FD=1, Bubble_DE=1; StallCount=1.
REQ-042 SHALL check branch beating load-use: LoadUse condition plus BranchJumpTaken=1 -> Flush_FD=1, Flush_DE=1, PCWrite=1, Bubble_DE=0.
REQ-043 SHALL check memory wait: MemStall pulse, MemDone after 5 cycles -> Freeze=1 for 6 cycles total, back to RUN, StallCount=6.
REQ-044 SHALL check watchdog: MemStall pulse, no MemDone -> Err=1 and Halted=1 at cycle 256; both hold until rst.
REQ-045 SHALL check halt: Halt=1 -> Halted=1 and PCWrite=0 permanently; rst=1 -> Halted=0, StallCount=0.
REQ-046 SHALL check saturation: force 70000 stall cycles -> StallCount=0xFFFF, no wrap.
